decoder2_4_arbiter: RTL
=======================

# decoder2_4_arbiter

Round-robin arbiter that shares the 2-to-4 decoder (`decoder2_4`) between four requesters. It selects one owner at a time and drives the decoder's `in1`/`in2` select and `enable` so exactly one decoder output line is active for the current owner. A registered one-hot `gnt` bus mirrors the decoder output for requesters that cannot see the decoder. A hold-limit counter bounds how long one owner may keep the resource while others wait. A one-cycle break-before-make gap separates successive grants.

## Interface
- `MAX_HOLD`, 16: maximum cycles an owner keeps the grant while any other request is pending; legal range 1..255.
- `sys_clk`  input  1  system clock; all state updates on the rising edge.
- `sys_rst_n`  input  1  reset; asynchronous, active-low.
- `req`  input  4  request per requester; level-sensitive; held high for as long as the resource is wanted.
- `dec_in1`  output  1  decoder select MSB; equals `owner[1]`.
- `dec_in2`  output  1  decoder select LSB; equals `owner[0]`.
- `dec_en`  output  1  decoder enable; high only in GRANT.
- `gnt`  output  4  one-hot grant; `gnt[owner]`=1 in GRANT, 0000 otherwise.
- `busy`  output  1  high in GRANT and RELEASE.

## Operation
- All outputs are registered.
- Reset values:
  - `dec_in1`=0, `dec_in2`=0, `dec_en`=0, `gnt`=0000, `busy`=0.
  - state=IDLE, `last_owner`=3, `hold_cnt`=0.
- Round-robin search starts at `last_owner`+1 (mod 4) and takes the first set `req` bit. After reset, `req[0]` has top priority.
- States:
  - IDLE: if `req`≠0, set owner to the RR winner and go to GRANT; otherwise stay.
  - GRANT: `dec_en`=1, `gnt`=one-hot(owner), `hold_cnt` increments each cycle.
    - Exit to RELEASE when `req[owner]`=0 is sampled.
    - Also exit to RELEASE when `hold_cnt`=MAX_HOLD-1 and any other `req` bit is set (preemption).
    - If no other request is pending, `hold_cnt` saturates at MAX_HOLD-1 and the grant continues indefinitely.
  - RELEASE: lasts exactly one cycle with `dec_en`=0 and `gnt`=0000. `last_owner`←owner, `hold_cnt`←0.
    - If `req`≠0, go to GRANT with the new RR winner, which may be the same requester if it is the only one requesting.
    - Otherwise go to IDLE.
- `dec_in1`/`dec_in2` update only on entry to GRANT and hold their value in IDLE and RELEASE.
- Owner width is 2 bits; `last_owner`+1 wraps 3→0.
- `hold_cnt` is 8 bits, unsigned, and never exceeds MAX_HOLD-1.
- Invariants:
  - `gnt` is zero or one-hot.
  - `gnt` equals the decoder output for ({`dec_in1`,`dec_in2`}, `dec_en`).
  - `gnt` never changes directly from one nonzero value to another.

## Timing
- Request to grant: `req` sampled at edge k in IDLE gives `gnt`/`dec_en` valid after edge k. Latency is 1 cycle.
- Owner drop: `req[owner]` deasserted before edge k gives `gnt`=0000 after edge k. The next grant is valid after edge k+1 at the earliest.
- Handover: the gap between two grants is exactly one RELEASE cycle.
- Preemption: an owner that is continuously requesting and contested holds `gnt` for exactly MAX_HOLD cycles.
- Simultaneous owner drop and hold expiry: treated as a single release. There is one RELEASE cycle and RR advances from the owner.
- Requests arriving during RELEASE are arbitrated at the RELEASE→GRANT edge.
- Reset mid-operation: `sys_rst_n` low clears every output and all state immediately, with no clock edge needed. After release, the first grant goes to `req[0]` if it is set.

## Test plan
- Reset: hold `sys_rst_n`=0 with `req`=1111. Expect `gnt`=0000, `dec_en`=0, `dec_in1`=`dec_in2`=0, `busy`=0 throughout.
- Single requester: assert `req`=0100 for 5 cycles, then 0000.
  - One cycle after assertion: `gnt`=0100, `dec_in1`=1, `dec_in2`=0, `dec_en`=1.
  - One cycle after the drop: `gnt`=0000, `busy`=1 (RELEASE).
  - Next cycle: IDLE, `busy`=0.
- Full contention with MAX_HOLD=4, `req`=1111 held: `gnt` sequence is 0001×4, 0000, 0010×4, 0000, 0100×4, 0000, 1000×4, 0000, 0001×4.
- Uncontested hold with MAX_HOLD=16: `req`=0010 held 40 cycles. Expect `gnt`=0010 continuously for 40 cycles with no gap; `hold_cnt` stays at 15.
- Simultaneous events with MAX_HOLD=4, owner 0, `req`=0011:
  - Drop `req[0]` in the same cycle `hold_cnt` reaches 3.
  - Expect one RELEASE cycle, then `gnt`=0010.
- Async reset mid-grant:
  - Pulse `sys_rst_n` low between clock edges while `gnt`=1000. Outputs must go to 0 immediately.
  - After release with `req`=1111, the first grant is 0001.

Source files
------------

// File: rtl/decoder2_4_arbiter.sv
// Round-robin owner selection for a shared 2-to-4 decoder, with a bounded hold
// time under contention and a one-cycle break-before-make gap between owners.
module decoder2_4_arbiter #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [3:0] req,
    output logic       dec_in1,
    output logic       dec_in2,
    output logic       dec_en,
    output logic [3:0] gnt,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_e;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_e     state_q, state_d;
    logic [1:0] owner_q, owner_d;
    logic [1:0] last_owner_q, last_owner_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic       dec_en_q, dec_en_d;
    logic [3:0] gnt_q, gnt_d;
    logic       busy_q, busy_d;
    logic       others_pending;
    logic       hold_expired;

    // First set request strictly after base, wrapping; base itself comes last.
    function automatic logic [1:0] rr_pick(input logic [1:0] base, input logic [3:0] r);
        logic [1:0] idx;
        logic [1:0] pick;
        logic       found;
        pick  = base;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = base + 2'(i);
            if (!found && r[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [3:0] decode(input logic [1:0] sel, input logic en);
        logic [3:0] y;
        y = 4'b0000;
        if (en) y[sel] = 1'b1;
        return y;
    endfunction

    assign others_pending = |(req & ~(4'b0001 << owner_q));
    assign hold_expired   = (hold_cnt_q == HOLD_LAST);

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        hold_cnt_d   = hold_cnt_q;

        unique case (state_q)
            IDLE: begin
                hold_cnt_d = 8'd0;
                if (|req) begin
                    owner_d = rr_pick(last_owner_q, req);
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!hold_expired) hold_cnt_d = hold_cnt_q + 8'd1;
                // A drop and a hold expiry on the same edge collapse into one release.
                if (!req[owner_q] || (hold_expired && others_pending)) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                last_owner_d = owner_q;
                hold_cnt_d   = 8'd0;
                if (|req) begin
                    owner_d = rr_pick(owner_q, req);
                    state_d = GRANT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d    = IDLE;
                hold_cnt_d = 8'd0;
            end
        endcase

        dec_en_d = (state_d == GRANT);
        gnt_d    = decode(owner_d, dec_en_d);
        busy_d   = (state_d != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= IDLE;
            owner_q      <= 2'd0;
            last_owner_q <= 2'd3;
            hold_cnt_q   <= 8'd0;
            dec_en_q     <= 1'b0;
            gnt_q        <= 4'b0000;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            hold_cnt_q   <= hold_cnt_d;
            dec_en_q     <= dec_en_d;
            gnt_q        <= gnt_d;
            busy_q       <= busy_d;
        end
    end

    assign dec_in1 = owner_q[1];
    assign dec_in2 = owner_q[0];
    assign dec_en  = dec_en_q;
    assign gnt     = gnt_q;
    assign busy    = busy_q;

    a_gnt_onehot0 : assert property (@(posedge sys_clk) disable iff (!sys_rst_n)
        $onehot0(gnt_q));

    a_gnt_matches_decoder : assert property (@(posedge sys_clk) disable iff (!sys_rst_n)
        gnt_q == decode(owner_q, dec_en_q));

    a_break_before_make : assert property (@(posedge sys_clk) disable iff (!sys_rst_n)
        ((gnt_q != 4'b0000) && ($past(gnt_q) != 4'b0000)) |-> (gnt_q == $past(gnt_q)));

    a_hold_bounded : assert property (@(posedge sys_clk) disable iff (!sys_rst_n)
        hold_cnt_q <= HOLD_LAST);

endmodule
